join_match_stage: RTL and testbench
===================================

Name: join_match_stage

Overview:
- Stage directly downstream of the branch/flag stage in the JOIN pipeline.
- Consumes 38-bit packets whose bit 18 (MF) marks a two-operand destination.
- Single-operand packets pass through. Two-operand packets wait in a direct-mapped matching store until their partner arrives, then leave as one merged 54-bit operand-pair packet.
- Clocked valid/ack handshake on both sides.

Parameters:
- ADDR_W, 6, matching-store index width. Store has 2**ADDR_W entries indexed by dest[ADDR_W-1:0]. Legal range 1..7.

Ports:
- CP  input  1  clock; all state updates on rising edge.
- MR  input  1  reset; synchronous, active-high.
- PACKET_IN  input  38  [37:27] tag, [26:20] dest, [19] port (0=left, 1=right), [18] MF, [17:0] data.
- Send_in  input  1  upstream packet valid.
- Ack_out  output  1  stage can accept; transfer when Send_in && Ack_out at CP edge.
- PACKET_OUT  output  54  [53:43] tag, [42:36] dest, [35:18] left data, [17:0] right data.
- Send_out  output  1  output packet valid.
- Ack_in  input  1  downstream accepts; drain when Send_out && Ack_in at CP edge.
- ERR  output  1  sticky collision flag.

Behaviour:
- Reset (MR=1 at edge):
  - Send_out=0, PACKET_OUT=0, ERR=0.
  - All entry valid bits cleared; entry payload is not cleared.
  - Reset overrides any simultaneous transfer. Reset mid-wait discards all waiting operands.
- Ack_out = !ERR && (!Send_out || Ack_in). This path is combinational from Ack_in and ERR.
- Entry contents: valid, tag[10:0], dest[6:0], port, data[17:0]. Lookup reads entry dest[ADDR_W-1:0] combinationally.
- Key match: entry.valid, entry.tag == tag, entry.dest == dest (full 7 bits), and entry.port != port.
- Accepted packet, MF=0 (pass-through):
  - Output {tag, dest, data, 18'b0} on the next edge. Port bit is ignored.
  - Store is untouched.
- Accepted packet, MF=1, entry invalid (store):
  - Write entry, set valid. No output is produced.
  - Send_out falls if it was being drained in the same edge.
- Accepted packet, MF=1, key match (fire):
  - Clear entry valid.
  - Output {tag, dest, left, right}, where left/right are chosen by each packet's port bit.
  - Latency 1 cycle: Send_out is high in the cycle after acceptance.
- Packet presented, MF=1, entry valid but key mismatch (collision):
  - The packet is not written, and the entry is unchanged.
  - ERR sets on that edge and stays set until MR. While ERR=1, Ack_out=0 (stage stalls).
  - Collision is detected whenever Send_in=1 and the stage would otherwise accept. The offending packet stays on PACKET_IN.
- Output register:
  - Holds PACKET_OUT and Send_out stable while Send_out && !Ack_in.
  - On drain with no new output, Send_out falls; PACKET_OUT keeps its last value.
  - Simultaneous drain and new output: reload, Send_out stays 1, full throughput of 1 packet/cycle.
- Back-to-back packets to the same index: the second sees the store state written by the first edge (no forwarding hazard, because lookup is after the write).
- Index aliasing (ADDR_W<7): different dests on the same index are treated as a collision.

Optional Feature:
- Macro JOIN_OCC_CNT_EN.
- Defined:
  - Adds output WAIT_CNT [ADDR_W:0], the count of valid entries.
  - +1 on store, -1 on fire, unchanged on pass-through or collision. Reset to 0.
  - Never wraps; the range 0..2**ADDR_W is guaranteed by the store.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Pass-through: reset, then PACKET_IN tag=5, dest=3, MF=0, data=18'h00ABC, Ack_in=1 -> next cycle Send_out=1, PACKET_OUT={11'd5, 7'd3, 18'h00ABC, 18'h0}; store count 0.
- Pair fire:
  - Send left (port 0, dest=2, tag=1, MF=1, data=18'h11111), then right (port 1, same key, data=18'h22222).
  - Expect no output after the first packet.
  - After the second: PACKET_OUT={11'd1, 7'd2, 18'h11111, 18'h22222}, entry 2 invalid, WAIT_CNT 1->0.
- Reverse order: right first, then left with the same key -> identical merged output (left/right placed by port bit).
- Backpressure: Ack_in=0 with Send_out=1 -> Ack_out=0, PACKET_OUT stable for 5 cycles. Ack_in=1 with Send_in=1 continuously -> one packet per cycle, none lost or duplicated.
- Collision: store dest=4, tag=7, port=0; present dest=4, tag=8, MF=1 -> ERR=1 next cycle, Ack_out=0 thereafter, entry 4 still tag 7. MR pulse -> ERR=0, entry invalid.
- Reset mid-operation: store 3 operands, assert MR for 1 cycle while Send_out=1 -> Send_out=0, WAIT_CNT=0. A later partner packet is stored, not fired.

Source files
------------

// File: rtl/join_match_stage.sv
// rtl/join_match_stage.sv - JOIN operand matching stage with direct-mapped matching store
//
// Single-operand packets (MF=0) pass straight through to the output register.
// Two-operand packets (MF=1) wait in a direct-mapped store indexed by
// dest[ADDR_W-1:0] until the partner with the same tag/dest and opposite port
// arrives, then leave as one merged operand-pair packet.
//
// Optional feature macro: JOIN_OCC_CNT_EN (adds WAIT_CNT occupancy output).
//
// Ports:
//   CP          clock, rising edge
//   MR          synchronous active-high reset
//   PACKET_IN   [37:27] tag, [26:20] dest, [19] port, [18] MF, [17:0] data
//   Send_in     upstream packet valid
//   Ack_out     stage can accept this cycle
//   PACKET_OUT  [53:43] tag, [42:36] dest, [35:18] left data, [17:0] right data
//   Send_out    output packet valid
//   Ack_in      downstream accepts
//   ERR         sticky collision flag
//   WAIT_CNT    number of valid store entries (JOIN_OCC_CNT_EN only)

module join_match_stage #(
    parameter int ADDR_W = 6
) (
    input  logic        CP,
    input  logic        MR,
    input  logic [37:0] PACKET_IN,
    input  logic        Send_in,
    output logic        Ack_out,
    output logic [53:0] PACKET_OUT,
    output logic        Send_out,
    input  logic        Ack_in,
    output logic        ERR
`ifdef JOIN_OCC_CNT_EN
    ,
    output logic [ADDR_W:0] WAIT_CNT
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [10:0]       in_tag;
    logic [6:0]        in_dest;
    logic              in_port;
    logic              in_mf;
    logic [17:0]       in_data;
    logic [ADDR_W-1:0] idx;

    logic [DEPTH-1:0]  ent_valid;
    logic [10:0]       ent_tag  [DEPTH];
    logic [6:0]        ent_dest [DEPTH];
    logic              ent_port [DEPTH];
    logic [17:0]       ent_data [DEPTH];

    logic        accept;
    logic        key_hit;
    logic        do_pass;
    logic        do_store;
    logic        do_fire;
    logic        do_coll;
    logic        new_out;
    logic [53:0] new_pkt;

    assign in_tag  = PACKET_IN[37:27];
    assign in_dest = PACKET_IN[26:20];
    assign in_port = PACKET_IN[19];
    assign in_mf   = PACKET_IN[18];
    assign in_data = PACKET_IN[17:0];
    assign idx     = in_dest[ADDR_W-1:0];

    // Ready whenever the output register is empty or being drained this edge.
    assign Ack_out = !ERR && (!Send_out || Ack_in);
    assign accept  = Send_in && Ack_out;

    always_comb begin
        key_hit  = ent_valid[idx] && (ent_tag[idx] == in_tag) &&
                   (ent_dest[idx] == in_dest) && (ent_port[idx] != in_port);
        do_pass  = accept && !in_mf;
        do_store = accept && in_mf && !ent_valid[idx];
        do_fire  = accept && in_mf && key_hit;
        // Any occupied entry that is not our partner is a collision, including
        // a different dest aliasing onto the same index.
        do_coll  = accept && in_mf && ent_valid[idx] && !key_hit;
        new_out  = do_pass || do_fire;
        new_pkt  = {in_tag, in_dest, in_data, 18'h0};
        if (do_fire) begin
            if (in_port) begin
                new_pkt = {in_tag, in_dest, ent_data[idx], in_data};
            end else begin
                new_pkt = {in_tag, in_dest, in_data, ent_data[idx]};
            end
        end
    end

    // Control state: valid bits, error flag, output register.
    always_ff @(posedge CP) begin
        if (MR) begin
            ent_valid  <= '0;
            ERR        <= 1'b0;
            Send_out   <= 1'b0;
            PACKET_OUT <= '0;
        end else begin
            if (do_store) begin
                ent_valid[idx] <= 1'b1;
            end else if (do_fire) begin
                ent_valid[idx] <= 1'b0;
            end
            if (do_coll) begin
                ERR <= 1'b1;
            end
            if (new_out) begin
                Send_out   <= 1'b1;
                PACKET_OUT <= new_pkt;
            end else if (Send_out && Ack_in) begin
                Send_out <= 1'b0;
            end
        end
    end

    // Entry payload is never reset; the valid bit alone qualifies it.
    always_ff @(posedge CP) begin
        if (!MR && do_store) begin
            ent_tag[idx]  <= in_tag;
            ent_dest[idx] <= in_dest;
            ent_port[idx] <= in_port;
            ent_data[idx] <= in_data;
        end
    end

`ifdef JOIN_OCC_CNT_EN
    always_ff @(posedge CP) begin
        if (MR) begin
            WAIT_CNT <= '0;
        end else if (do_store) begin
            WAIT_CNT <= WAIT_CNT + (ADDR_W + 1)'(1);
        end else if (do_fire) begin
            WAIT_CNT <= WAIT_CNT - (ADDR_W + 1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_join_match_stage.sv
// tb/tb_join_match_stage.sv - directed and randomized bench for join_match_stage

module tb_join_match_stage;

    logic        CP = 1'b0;
    logic        MR;
    logic [37:0] PACKET_IN;
    logic        Send_in;
    logic        Ack_out;
    logic [53:0] PACKET_OUT;
    logic        Send_out;
    logic        Ack_in;
    logic        ERR;
`ifdef JOIN_OCC_CNT_EN
    logic [6:0]  WAIT_CNT;
`endif

    int total = 0;
    int bad   = 0;

    join_match_stage #(.ADDR_W(6)) dut (
        .CP         (CP),
        .MR         (MR),
        .PACKET_IN  (PACKET_IN),
        .Send_in    (Send_in),
        .Ack_out    (Ack_out),
        .PACKET_OUT (PACKET_OUT),
        .Send_out   (Send_out),
        .Ack_in     (Ack_in),
        .ERR        (ERR)
`ifdef JOIN_OCC_CNT_EN
        ,
        .WAIT_CNT   (WAIT_CNT)
`endif
    );

    always #5 CP = ~CP;

    // Reference store: one slot per index, holding the waiting operand.
    logic        m_v    [64];
    logic [10:0] m_tag  [64];
    logic [6:0]  m_dest [64];
    logic        m_port [64];
    logic [17:0] m_data [64];
    logic        m_so;
    logic [53:0] m_po;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef JOIN_OCC_CNT_EN
        chk(tag, 64'(WAIT_CNT), 64'(exp));
`endif
    endtask

    function automatic logic [37:0] mk(input int tag, input int dest, input bit port,
                                       input bit mf, input logic [17:0] data);
        return {11'(tag), 7'(dest), port, mf, data};
    endfunction

    function automatic logic [53:0] pair(input int tag, input int dest,
                                         input logic [17:0] l, input logic [17:0] r);
        return {11'(tag), 7'(dest), l, r};
    endfunction

    task automatic cyc();
        @(posedge CP);
        #1;
    endtask

    // Present one packet for a single edge, then withdraw it.
    task automatic send(input logic [37:0] p, input logic ack);
        PACKET_IN = p;
        Send_in   = 1'b1;
        Ack_in    = ack;
        cyc();
        Send_in   = 1'b0;
    endtask

    task automatic do_reset();
        MR = 1'b1;
        Send_in = 1'b0;
        cyc();
        MR = 1'b0;
        for (int i = 0; i < 64; i++) m_v[i] = 1'b0;
        m_so = 1'b0;
    endtask

    logic [53:0] held;
    logic [37:0] cur;
    logic        pending;
    logic        exp_ack;
    int          j;
    int          nvalid;

    initial begin
        MR = 1'b1;
        PACKET_IN = '0;
        Send_in = 1'b0;
        Ack_in = 1'b0;
        cyc();
        cyc();
        MR = 1'b0;
        #1;
        chk("reset_send_out", 64'(Send_out), 64'd0);
        chk("reset_packet_out", 64'(PACKET_OUT), 64'd0);
        chk("reset_err", 64'(ERR), 64'd0);
        chk("reset_ack_out", 64'(Ack_out), 64'd1);
        chk_cnt("reset_cnt", 0);

        // Pass-through
        send(mk(5, 3, 1'b0, 1'b0, 18'h00ABC), 1'b1);
        chk("pass_send_out", 64'(Send_out), 64'd1);
        chk("pass_packet", 64'(PACKET_OUT), 64'(pair(5, 3, 18'h00ABC, 18'h0)));
        chk_cnt("pass_cnt", 0);
        cyc();
        chk("pass_drained", 64'(Send_out), 64'd0);

        // Pair fire, left then right
        send(mk(1, 2, 1'b0, 1'b1, 18'h11111), 1'b1);
        chk("pair_first_no_out", 64'(Send_out), 64'd0);
        chk_cnt("pair_cnt1", 1);
        send(mk(1, 2, 1'b1, 1'b1, 18'h22222), 1'b1);
        chk("pair_send_out", 64'(Send_out), 64'd1);
        chk("pair_packet", 64'(PACKET_OUT), 64'(pair(1, 2, 18'h11111, 18'h22222)));
        chk("pair_entry_clear", 64'(dut.ent_valid[2]), 64'd0);
        chk_cnt("pair_cnt0", 0);
        cyc();

        // Reverse order: right first
        send(mk(3, 9, 1'b1, 1'b1, 18'h33333), 1'b1);
        chk("rev_first_no_out", 64'(Send_out), 64'd0);
        send(mk(3, 9, 1'b0, 1'b1, 18'h04444), 1'b1);
        chk("rev_packet", 64'(PACKET_OUT), 64'(pair(3, 9, 18'h04444, 18'h33333)));
        cyc();

        // Backpressure: output held for 5 cycles
        send(mk(6, 1, 1'b0, 1'b0, 18'h00123), 1'b0);
        held = PACKET_OUT;
        chk("bp_loaded", 64'(held), 64'(pair(6, 1, 18'h00123, 18'h0)));
        for (int i = 0; i < 5; i++) begin
            chk("bp_send_out", 64'(Send_out), 64'd1);
            chk("bp_ack_out", 64'(Ack_out), 64'd0);
            chk("bp_stable", 64'(PACKET_OUT), 64'(held));
            cyc();
        end
        // Streaming at full throughput
        Ack_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            PACKET_IN = mk(20 + i, i, 1'b0, 1'b0, 18'(i * 7 + 1));
            Send_in = 1'b1;
            #1;
            chk("stream_ack", 64'(Ack_out), 64'd1);
            cyc();
            chk("stream_send_out", 64'(Send_out), 64'd1);
            chk("stream_packet", 64'(PACKET_OUT), 64'(pair(20 + i, i, 18'(i * 7 + 1), 18'h0)));
        end
        Send_in = 1'b0;
        cyc();
        chk("stream_drained", 64'(Send_out), 64'd0);

        // Collision
        send(mk(7, 4, 1'b0, 1'b1, 18'h07777), 1'b1);
        PACKET_IN = mk(8, 4, 1'b0, 1'b1, 18'h08888);
        Send_in = 1'b1;
        #1;
        chk("coll_pre_ack", 64'(Ack_out), 64'd1);
        cyc();
        chk("coll_err", 64'(ERR), 64'd1);
        for (int i = 0; i < 3; i++) begin
            chk("coll_stall", 64'(Ack_out), 64'd0);
            chk("coll_no_out", 64'(Send_out), 64'd0);
            cyc();
        end
        chk("coll_entry_tag", 64'(dut.ent_tag[4]), 64'd7);
        chk("coll_entry_valid", 64'(dut.ent_valid[4]), 64'd1);
        chk_cnt("coll_cnt", 1);
        do_reset();
        chk("coll_err_cleared", 64'(ERR), 64'd0);
        chk("coll_entry_cleared", 64'(dut.ent_valid[4]), 64'd0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) send(mk(2, 10 + i, 1'b0, 1'b1, 18'(i)), 1'b1);
        send(mk(9, 1, 1'b0, 1'b0, 18'h1), 1'b0);
        chk("mid_send_out", 64'(Send_out), 64'd1);
        chk_cnt("mid_cnt3", 3);
        do_reset();
        chk("mid_reset_send_out", 64'(Send_out), 64'd0);
        chk_cnt("mid_reset_cnt", 0);
        send(mk(2, 10, 1'b1, 1'b1, 18'h5), 1'b1);
        chk("mid_partner_stored", 64'(Send_out), 64'd0);
        chk_cnt("mid_partner_cnt", 1);

        // Randomized traffic against the reference store (collision-free)
        do_reset();
        pending = 1'b0;
        cur = '0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_send_out", 64'(Send_out), 64'(m_so));
            if (m_so) chk("rnd_packet", 64'(PACKET_OUT), 64'(m_po));
            chk("rnd_err", 64'(ERR), 64'd0);
            nvalid = 0;
            for (int i = 0; i < 64; i++) nvalid += int'(m_v[i]);
            chk_cnt("rnd_cnt", nvalid);

            if (!pending && ($urandom % 10) < 7) begin
                j = int'($urandom % 64);
                case ($urandom % 3)
                    0: cur = mk(int'($urandom % 2048), int'($urandom % 128), 1'($urandom),
                                1'b0, 18'($urandom));
                    1: begin
                        cur = mk(int'($urandom % 2048), 0, 1'b0, 1'b0, 18'($urandom));
                        for (int k = 0; k < 64; k++) begin
                            if (m_v[(j + k) % 64]) begin
                                j = (j + k) % 64;
                                cur = mk(int'(m_tag[j]), int'(m_dest[j]), !m_port[j],
                                         1'b1, 18'($urandom));
                                break;
                            end
                        end
                    end
                    default: begin
                        cur = mk(int'($urandom % 2048), 0, 1'b0, 1'b0, 18'($urandom));
                        for (int k = 0; k < 64; k++) begin
                            if (!m_v[(j + k) % 64]) begin
                                j = (j + k) % 64;
                                cur = mk(int'($urandom % 2048), j + 64 * int'($urandom % 2),
                                         1'($urandom), 1'b1, 18'($urandom));
                                break;
                            end
                        end
                    end
                endcase
                pending = 1'b1;
            end
            PACKET_IN = pending ? cur : 38'($urandom);
            Send_in = pending;
            Ack_in = ($urandom % 4) != 0;
            #1;
            exp_ack = !m_so || Ack_in;
            chk("rnd_ack_out", 64'(Ack_out), 64'(exp_ack));

            // Model the coming edge from the pre-edge state.
            if (pending && exp_ack) begin
                j = int'(cur[25:20]);
                if (!cur[18]) begin
                    m_so = 1'b1;
                    m_po = {cur[37:20], cur[17:0], 18'h0};
                end else if (m_v[j]) begin
                    m_so = 1'b1;
                    m_po = cur[19] ? {cur[37:20], m_data[j], cur[17:0]}
                                   : {cur[37:20], cur[17:0], m_data[j]};
                    m_v[j] = 1'b0;
                end else begin
                    m_v[j] = 1'b1;
                    m_tag[j] = cur[37:27];
                    m_dest[j] = cur[26:20];
                    m_port[j] = cur[19];
                    m_data[j] = cur[17:0];
                    if (Ack_in) m_so = 1'b0;
                end
                pending = 1'b0;
            end else if (m_so && Ack_in) begin
                m_so = 1'b0;
            end
            @(posedge CP);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
